// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core types and constants for the register unit
package riscv_pkg;

    localparam int XLEN = 32;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_SP   = 5'd2;

    // Write-back select encodings used by the control unit
    localparam logic [1:0] RUW_ALU = 2'b00;
    localparam logic [1:0] RUW_MEM = 2'b01;
    localparam logic [1:0] RUW_PC4 = 2'b10;

endpackage

// File: rtl/register_unit_if.sv
// rtl/register_unit_if.sv - register unit read/write/scoreboard bus
interface register_unit_if;
    import riscv_pkg::*;

    logic            RUWr;
    reg_idx_t        rd;
    logic [XLEN-1:0] DataWr;
    reg_idx_t        rs1;
    reg_idx_t        rs2;
    logic [XLEN-1:0] RUrs1;
    logic [XLEN-1:0] RUrs2;
    logic            issue_valid;
    reg_idx_t        issue_rd;
    logic            busy_rs1;
    logic            busy_rs2;
    logic            stall;

    // Core pipeline side: drives indices, write-back and issue
    modport master (
        output RUWr, rd, DataWr, rs1, rs2, issue_valid, issue_rd,
        input  RUrs1, RUrs2, busy_rs1, busy_rs2, stall
    );

    // Register unit side
    modport slave (
        input  RUWr, rd, DataWr, rs1, rs2, issue_valid, issue_rd,
        output RUrs1, RUrs2, busy_rs1, busy_rs2, stall
    );

endinterface

// File: rtl/register_scoreboard.sv
// rtl/register_scoreboard.sv - per-register pending bits for multi-cycle producers
module register_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     clr_en,
    input  reg_idx_t clr_idx,
    input  reg_idx_t rs1,
    input  reg_idx_t rs2,
    output logic     busy_rs1,
    output logic     busy_rs2
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    // Next pending state: clear on write-back first, then a new issue takes
    // ownership so a same-index set wins. x0 is never marked.
    always_comb begin
        pending_d = pending_q;
        if (clr_en && clr_idx != REG_ZERO) begin
            pending_d[clr_idx] = 1'b0;
        end
        if (set_en && set_idx != REG_ZERO) begin
            pending_d[set_idx] = 1'b1;
        end
    end

    // Pending register with synchronous reset that forgets all in-flight loads
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // A write-back landing this cycle resolves the hazard through the bypass
    always_comb begin
        busy_rs1 = pending_q[rs1] && !(clr_en && clr_idx == rs1);
        busy_rs2 = pending_q[rs2] && !(clr_en && clr_idx == rs2);
    end

endmodule

// File: rtl/register_unit.sv
// rtl/register_unit.sv - 32x32 architectural register file with bypass and scoreboard
module register_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] SP_RESET = 32'h0000_03FC
) (
    input  logic           clk,
    input  logic           rst,
    register_unit_if.slave bus
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            wr_live;

    assign wr_live = bus.RUWr && (bus.rd != REG_ZERO);

    // Next array contents: one write port, x0 never written
    always_comb begin
        regs_d = regs_q;
        if (wr_live) begin
            regs_d[bus.rd] = bus.DataWr;
        end
    end

    // Array storage; reset zeroes everything except the stack pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            regs_q[REG_SP] <= SP_RESET;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational read ports with write-through bypass and hardwired x0
    always_comb begin
        if (bus.rs1 == REG_ZERO) begin
            bus.RUrs1 = '0;
        end else if (bus.RUWr && bus.rd == bus.rs1) begin
            bus.RUrs1 = bus.DataWr;
        end else begin
            bus.RUrs1 = regs_q[bus.rs1];
        end

        if (bus.rs2 == REG_ZERO) begin
            bus.RUrs2 = '0;
        end else if (bus.RUWr && bus.rd == bus.rs2) begin
            bus.RUrs2 = bus.DataWr;
        end else begin
            bus.RUrs2 = regs_q[bus.rs2];
        end
    end

    logic busy1;
    logic busy2;

    register_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (bus.issue_valid),
        .set_idx  (bus.issue_rd),
        .clr_en   (bus.RUWr),
        .clr_idx  (bus.rd),
        .rs1      (bus.rs1),
        .rs2      (bus.rs2),
        .busy_rs1 (busy1),
        .busy_rs2 (busy2)
    );

    assign bus.busy_rs1 = busy1;
    assign bus.busy_rs2 = busy2;
    assign bus.stall    = busy1 | busy2;

endmodule
